// File: rtl/lsq_param_if.sv
// Dispatch/ROB/CDB/memory-controller bundle seen by the load/store queue.
// The master side is the rest of the core; the slave side is the queue.
interface lsq_param_if #(
    parameter int unsigned ROB_W = 4,
    parameter int unsigned NCDB  = 2
);
    logic                    rdy;
    logic                    rollback;
    logic                    lsq_nxt_full;
    logic                    issue;
    logic [ROB_W-1:0]        issue_rob_pos;
    logic                    issue_is_store;
    logic [2:0]              issue_funct3;
    logic [31:0]             issue_rs1_val;
    logic [ROB_W:0]          issue_rs1_rob_id;
    logic [31:0]             issue_rs2_val;
    logic [ROB_W:0]          issue_rs2_rob_id;
    logic [31:0]             issue_imm;
    logic [ROB_W-1:0]        rob_head_pos;
    logic                    commit_store;
    logic [ROB_W-1:0]        commit_rob_pos;
    logic [NCDB-1:0]         cdb_valid;
    logic [NCDB*ROB_W-1:0]   cdb_rob_pos;
    logic [NCDB*32-1:0]      cdb_val;
    logic                    mc_en;
    logic                    mc_wr;
    logic [31:0]             mc_addr;
    logic [2:0]              mc_len;
    logic [31:0]             mc_w_data;
    logic                    mc_done;
    logic [31:0]             mc_r_data;
    logic                    result;
    logic [ROB_W-1:0]        result_rob_pos;
    logic [31:0]             result_val;

    modport master (
        output rdy, rollback, issue, issue_rob_pos, issue_is_store, issue_funct3,
               issue_rs1_val, issue_rs1_rob_id, issue_rs2_val, issue_rs2_rob_id, issue_imm,
               rob_head_pos, commit_store, commit_rob_pos, cdb_valid, cdb_rob_pos, cdb_val,
               mc_done, mc_r_data,
        input  lsq_nxt_full, mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
               result, result_rob_pos, result_val
    );

    modport slave (
        input  rdy, rollback, issue, issue_rob_pos, issue_is_store, issue_funct3,
               issue_rs1_val, issue_rs1_rob_id, issue_rs2_val, issue_rs2_rob_id, issue_imm,
               rob_head_pos, commit_store, commit_rob_pos, cdb_valid, cdb_rob_pos, cdb_val,
               mc_done, mc_r_data,
        output lsq_nxt_full, mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
               result, result_rob_pos, result_val
    );
endinterface

// File: rtl/lsq_param.sv
// In-order load/store queue between dispatch and the memory controller.
// Loads go out speculatively (IO loads only at ROB head), stores only once
// committed. A rollback keeps committed stores and lets an in-flight load
// drain silently.
//
// state    | meaning
// IDLE     | no MC request outstanding; start one when the head is eligible
// WAIT_MEM | request held on mc_*; pop head on mc_done
module lsq_param #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned NCDB    = 2,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic       clk,
    input  logic       rst,
    lsq_param_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = ROB_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    logic [DEPTH-1:0] valid, is_store, committed, commit_hit;
    logic [ROB_W-1:0] rob_pos [DEPTH];
    logic [2:0]       funct3  [DEPTH];
    logic [31:0]      rs1_val [DEPTH];
    logic [31:0]      rs2_val [DEPTH];
    logic [31:0]      imm     [DEPTH];
    logic [TW-1:0]    rs1_tag [DEPTH];
    logic [TW-1:0]    rs2_tag [DEPTH];
    logic [PW-1:0]    head, tail, head_nxt, tail_nxt;
    logic [CW-1:0]    count, ncommit, count_nxt, ncommit_nxt, keep;
    logic             squash, squash_start;
    logic             head_elig, start_req, pop, pop_commit, issue_ok;
    logic [31:0]      head_addr;
    state_t           state, state_nxt;

    // Apply every CDB channel to one operand; lowest channel wins on a tag clash.
    function automatic logic [TW+31:0] snoop(input logic [TW-1:0] tag, input logic [31:0] val);
        logic [TW+31:0] r;
        r = {tag, val};
        for (int k = NCDB - 1; k >= 0; k--)
            if (tag[ROB_W] && bus.cdb_valid[k] && tag[ROB_W-1:0] == bus.cdb_rob_pos[k*ROB_W +: ROB_W])
                r = {1'b0, tag[ROB_W-1:0], bus.cdb_val[k*32 +: 32]};
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'd0, d[7:0]};
            3'b101:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign head_addr = rs1_val[head] + imm[head];
    assign head_elig = (count != '0) && !rs1_tag[head][ROB_W] && !rs2_tag[head][ROB_W] &&
                       ((is_store[head] && committed[head]) ||
                        (!is_store[head] && !bus.rollback &&
                         (head_addr < IO_BASE || rob_pos[head] == bus.rob_head_pos)));

    // State register.
    always_ff @(posedge clk) begin
        if (rst)          state <= IDLE;
        else if (bus.rdy) state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (head_elig)   state_nxt = WAIT_MEM;
            WAIT_MEM: if (bus.mc_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM strobes: request launch and head pop.
    always_comb begin
        start_req = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE:     start_req = bus.rdy && head_elig;
            WAIT_MEM: pop       = bus.rdy && bus.mc_done;
            default:  ;
        endcase
    end

    // Queue bookkeeping: commit search, pointer and occupancy updates.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            commit_hit[i] = bus.commit_store && !bus.rollback && valid[i] && is_store[i] &&
                            !committed[i] && rob_pos[i] == bus.commit_rob_pos;
        pop_commit   = pop && is_store[head] && committed[head];
        squash_start = bus.rollback && state == WAIT_MEM && !bus.mc_done && !is_store[head];
        issue_ok     = bus.issue && !bus.rollback && (count != FULL || pop);
        head_nxt     = head + PW'(pop);
        ncommit_nxt  = ncommit + CW'(|commit_hit) - CW'(pop_commit);
        keep         = ncommit_nxt + CW'(squash_start);
        if (bus.rollback) begin
            tail_nxt  = head_nxt + keep[PW-1:0];
            count_nxt = keep;
        end else begin
            tail_nxt  = tail + PW'(issue_ok);
            count_nxt = count + CW'(issue_ok) - CW'(pop);
        end
    end

    assign bus.lsq_nxt_full = rst ? 1'b0 : (bus.rdy ? (count_nxt == FULL) : (count == FULL));

    // Entry storage: snoop, commit marking, rollback drop, pop and enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            committed <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ncommit   <= '0;
        end else if (bus.rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                {rs1_tag[i], rs1_val[i]} <= snoop(rs1_tag[i], rs1_val[i]);
                {rs2_tag[i], rs2_val[i]} <= snoop(rs2_tag[i], rs2_val[i]);
                if (commit_hit[i]) committed[i] <= 1'b1;
                if (bus.rollback && !committed[i] && !(squash_start && PW'(i) == head))
                    valid[i] <= 1'b0;
            end
            if (pop) begin
                valid[head]     <= 1'b0;
                committed[head] <= 1'b0;
            end
            if (issue_ok) begin
                valid[tail]                <= 1'b1;
                committed[tail]            <= 1'b0;
                is_store[tail]             <= bus.issue_is_store;
                rob_pos[tail]              <= bus.issue_rob_pos;
                funct3[tail]               <= bus.issue_funct3;
                imm[tail]                  <= bus.issue_imm;
                {rs1_tag[tail], rs1_val[tail]} <= snoop(bus.issue_rs1_rob_id, bus.issue_rs1_val);
                {rs2_tag[tail], rs2_val[tail]} <= snoop(bus.issue_rs2_rob_id, bus.issue_rs2_val);
            end
            head    <= head_nxt;
            tail    <= tail_nxt;
            count   <= count_nxt;
            ncommit <= ncommit_nxt;
        end
    end

    // MC request registers, load result and squash flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mc_en          <= 1'b0;
            bus.mc_wr          <= 1'b0;
            bus.mc_addr        <= '0;
            bus.mc_len         <= '0;
            bus.mc_w_data      <= '0;
            bus.result         <= 1'b0;
            bus.result_rob_pos <= '0;
            bus.result_val     <= '0;
            squash             <= 1'b0;
        end else if (bus.rdy) begin
            bus.result <= 1'b0;
            if (start_req) begin
                bus.mc_en     <= 1'b1;
                bus.mc_wr     <= is_store[head];
                bus.mc_addr   <= head_addr;
                bus.mc_w_data <= rs2_val[head];
                case (funct3[head][1:0])
                    2'b00:   bus.mc_len <= 3'd1;
                    2'b01:   bus.mc_len <= 3'd2;
                    default: bus.mc_len <= 3'd4;
                endcase
            end else if (pop) begin
                bus.mc_en <= 1'b0;
                if (!is_store[head]) begin
                    if (squash) begin
                        squash <= 1'b0;
                    end else begin
                        bus.result         <= 1'b1;
                        bus.result_rob_pos <= rob_pos[head];
                        bus.result_val     <= load_ext(funct3[head], bus.mc_r_data);
                    end
                end
            end
            if (squash_start) squash <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param: loads with extension, store commit, CDB
// snooping, full/wrap behaviour, IO gating, rollback squash and reset.
module tb_lsq_param;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lsq_param_if #(.ROB_W(4), .NCDB(2)) bus ();

    lsq_param #(.DEPTH(16), .ROB_W(4), .NCDB(2), .IO_BASE(32'h0003_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                             input logic [31:0] rs1, input logic [4:0] t1,
                             input logic [31:0] rs2, input logic [4:0] t2, input logic [31:0] imm);
        bus.issue_is_store   = st;
        bus.issue_funct3     = f3;
        bus.issue_rob_pos    = rob;
        bus.issue_rs1_val    = rs1;
        bus.issue_rs1_rob_id = t1;
        bus.issue_rs2_val    = rs2;
        bus.issue_rs2_rob_id = t2;
        bus.issue_imm        = imm;
    endtask

    task automatic push(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                        input logic [31:0] rs1, input logic [4:0] t1,
                        input logic [31:0] rs2, input logic [4:0] t2, input logic [31:0] imm);
        set_issue(st, f3, rob, rs1, t1, rs2, t2, imm);
        bus.issue = 1'b1;
        tick();
        bus.issue = 1'b0;
    endtask

    task automatic commit(input logic [3:0] rob);
        bus.commit_store   = 1'b1;
        bus.commit_rob_pos = rob;
        tick();
        bus.commit_store   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.mc_en && n < 30) begin
            tick();
            n++;
        end
        if (!bus.mc_en) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic mem_reply(input logic [31:0] data);
        bus.mc_r_data = data;
        bus.mc_done   = 1'b1;
        tick();
        bus.mc_done   = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [3:0] rob,
                             input logic [31:0] rdata, input logic [2:0] exp_len,
                             input logic [31:0] exp_val);
        push(1'b0, f3, rob, 32'h300, 5'd0, 32'd0, 5'd0, 32'd0);
        wait_req(tag);
        check_val({tag, "_len"}, {29'd0, bus.mc_len}, {29'd0, exp_len});
        mem_reply(rdata);
        check_val({tag, "_val"}, bus.result_val, exp_val);
        check_val({tag, "_rob"}, {28'd0, bus.result_rob_pos}, {28'd0, rob});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.rollback = 1'b0;
        bus.issue = 1'b0;
        set_issue(1'b0, 3'd0, 4'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.rob_head_pos = 4'd0;
        bus.commit_store = 1'b0;
        bus.commit_rob_pos = 4'd0;
        bus.cdb_valid = 2'b00;
        bus.cdb_rob_pos = 8'd0;
        bus.cdb_val = 64'd0;
        bus.mc_done = 1'b0;
        bus.mc_r_data = 32'd0;
        repeat (3) tick();
        rst = 1'b0;

        check_val("rst_mc_en", {31'd0, bus.mc_en}, 32'd0);
        check_val("rst_mc_addr", bus.mc_addr, 32'd0);
        check_val("rst_result", {31'd0, bus.result}, 32'd0);
        check_val("rst_nxt_full", {31'd0, bus.lsq_nxt_full}, 32'd0);

        // LW 0x100+4, frozen by rdy=0, then completed
        push(1'b0, 3'b010, 4'd0, 32'h100, 5'd0, 32'd0, 5'd0, 32'd4);
        wait_req("lw");
        check_val("lw_addr", bus.mc_addr, 32'h104);
        check_val("lw_len", {29'd0, bus.mc_len}, 32'd4);
        check_val("lw_wr", {31'd0, bus.mc_wr}, 32'd0);
        bus.rdy = 1'b0;
        bus.mc_r_data = 32'h1111_1111;
        bus.mc_done = 1'b1;
        tick();
        bus.mc_done = 1'b0;
        bus.rdy = 1'b1;
        check_val("frz_mc_en", {31'd0, bus.mc_en}, 32'd1);
        check_val("frz_result", {31'd0, bus.result}, 32'd0);
        tick();
        check_val("frz_hold", {31'd0, bus.mc_en}, 32'd1);
        mem_reply(32'hDEAD_BEEF);
        check_val("lw_result", {31'd0, bus.result}, 32'd1);
        check_val("lw_val", bus.result_val, 32'hDEAD_BEEF);
        tick();
        check_val("lw_result_1cyc", {31'd0, bus.result}, 32'd0);

        // sign/zero extension
        load_case("lb", 3'b000, 4'd1, 32'h80, 3'd1, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 4'd2, 32'h80, 3'd1, 32'h0000_0080);
        load_case("lh", 3'b001, 4'd3, 32'h8001, 3'd2, 32'hFFFF_8001);
        load_case("lhu", 3'b101, 4'd4, 32'h8001, 3'd2, 32'h0000_8001);

        // SW with rs2 pending on {1,3}; needs CDB then commit
        push(1'b1, 3'b010, 4'd4, 32'h200, 5'd0, 32'd0, 5'b10011, 32'd0);
        repeat (3) tick();
        check_val("sw_pending_no_req", {31'd0, bus.mc_en}, 32'd0);
        bus.cdb_valid = 2'b10;
        bus.cdb_rob_pos = {4'd3, 4'd0};
        bus.cdb_val = {32'h55, 32'h0};
        tick();
        bus.cdb_valid = 2'b00;
        repeat (3) tick();
        check_val("sw_uncommitted_no_req", {31'd0, bus.mc_en}, 32'd0);
        commit(4'd4);
        wait_req("sw");
        check_val("sw_wr", {31'd0, bus.mc_wr}, 32'd1);
        check_val("sw_wdata", bus.mc_w_data, 32'h55);
        check_val("sw_addr", bus.mc_addr, 32'h200);
        mem_reply(32'd0);
        check_val("sw_no_result", {31'd0, bus.result}, 32'd0);

        // issue-cycle broadcast on both channels for the same tag: channel 0 wins
        set_issue(1'b0, 3'b010, 4'd6, 32'd0, 5'b10110, 32'd0, 5'd0, 32'd8);
        bus.issue = 1'b1;
        bus.cdb_valid = 2'b11;
        bus.cdb_rob_pos = {4'd6, 4'd6};
        bus.cdb_val = {32'h400, 32'h300};
        tick();
        bus.issue = 1'b0;
        bus.cdb_valid = 2'b00;
        wait_req("cdb_clash");
        check_val("cdb_clash_addr", bus.mc_addr, 32'h308);
        mem_reply(32'd0);

        // fill with blocked IO loads
        bus.rob_head_pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            set_issue(1'b0, 3'b010, 4'd7, 32'h0003_0000, 5'd0, 32'd0, 5'd0, 32'(i * 4));
            bus.issue = 1'b1;
            #1;
            check_val($sformatf("fill_nxt_full_%0d", i), {31'd0, bus.lsq_nxt_full}, {31'd0, i == 15});
            tick();
        end
        bus.issue = 1'b0;
        #1;
        check_val("full_hold", {31'd0, bus.lsq_nxt_full}, 32'd1);
        set_issue(1'b0, 3'b010, 4'd3, 32'h999, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.issue = 1'b1;
        #1;
        check_val("full_drop_nxt_full", {31'd0, bus.lsq_nxt_full}, 32'd1);
        tick();
        bus.issue = 1'b0;
        check_val("io_blocked", {31'd0, bus.mc_en}, 32'd0);
        bus.rob_head_pos = 4'd7;
        wait_req("drain0");
        check_val("drain0_addr", bus.mc_addr, 32'h0003_0000);
        set_issue(1'b0, 3'b010, 4'd9, 32'h40, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.issue = 1'b1;
        bus.mc_r_data = 32'd0;
        bus.mc_done = 1'b1;
        #1;
        check_val("pop_push_nxt_full", {31'd0, bus.lsq_nxt_full}, 32'd1);
        tick();
        bus.issue = 1'b0;
        bus.mc_done = 1'b0;
        check_val("drain0_rob", {28'd0, bus.result_rob_pos}, 32'd7);
        for (int k = 1; k <= 16; k++) begin
            wait_req("drain");
            check_val($sformatf("drain%0d_addr", k), bus.mc_addr,
                      (k < 16) ? 32'h0003_0000 + 32'(k * 4) : 32'h40);
            mem_reply(32'(k));
            check_val($sformatf("drain%0d_rob", k), {28'd0, bus.result_rob_pos},
                      (k < 16) ? 32'd7 : 32'd9);
            check_val($sformatf("drain%0d_val", k), bus.result_val, 32'(k));
        end
        check_val("drained_nxt_full", {31'd0, bus.lsq_nxt_full}, 32'd0);

        // IO load waits for ROB head
        bus.rob_head_pos = 4'd2;
        push(1'b0, 3'b010, 4'd5, 32'h0003_0000, 5'd0, 32'd0, 5'd0, 32'd0);
        repeat (4) tick();
        check_val("io_wait", {31'd0, bus.mc_en}, 32'd0);
        bus.rob_head_pos = 4'd5;
        wait_req("io");
        check_val("io_addr", bus.mc_addr, 32'h0003_0000);
        mem_reply(32'h77);
        check_val("io_result", {31'd0, bus.result}, 32'd1);
        check_val("io_val", bus.result_val, 32'h77);

        // rollback with head load in flight, two committed stores behind it
        push(1'b0, 3'b010, 4'd8, 32'h10, 5'd0, 32'd0, 5'd0, 32'd0);
        push(1'b1, 3'b010, 4'd9, 32'h20, 5'd0, 32'hA1, 5'd0, 32'd0);
        push(1'b1, 3'b010, 4'd10, 32'h24, 5'd0, 32'hB2, 5'd0, 32'd0);
        push(1'b0, 3'b010, 4'd11, 32'h28, 5'd0, 32'd0, 5'd0, 32'd0);
        push(1'b0, 3'b010, 4'd12, 32'h2C, 5'd0, 32'd0, 5'd0, 32'd0);
        commit(4'd9);
        commit(4'd10);
        check_val("rb_inflight_addr", bus.mc_addr, 32'h10);
        bus.rollback = 1'b1;
        tick();
        bus.rollback = 1'b0;
        check_val("rb_hold_en", {31'd0, bus.mc_en}, 32'd1);
        mem_reply(32'h1234);
        check_val("rb_squashed_result", {31'd0, bus.result}, 32'd0);
        wait_req("rb_st0");
        check_val("rb_st0_addr", bus.mc_addr, 32'h20);
        check_val("rb_st0_wr", {31'd0, bus.mc_wr}, 32'd1);
        check_val("rb_st0_data", bus.mc_w_data, 32'hA1);
        mem_reply(32'd0);
        wait_req("rb_st1");
        check_val("rb_st1_addr", bus.mc_addr, 32'h24);
        check_val("rb_st1_data", bus.mc_w_data, 32'hB2);
        mem_reply(32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val("rb_dropped_no_req", {31'd0, bus.mc_en}, 32'd0);
        end
        push(1'b0, 3'b010, 4'd13, 32'h50, 5'd0, 32'd0, 5'd0, 32'd0);
        wait_req("rb_after");
        check_val("rb_after_addr", bus.mc_addr, 32'h50);
        mem_reply(32'h9);
        check_val("rb_after_result", {31'd0, bus.result}, 32'd1);
        check_val("rb_after_rob", {28'd0, bus.result_rob_pos}, 32'd13);

        // reset abandons an outstanding request
        push(1'b0, 3'b010, 4'd1, 32'h60, 5'd0, 32'd0, 5'd0, 32'd0);
        wait_req("rst_mid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_mid_en", {31'd0, bus.mc_en}, 32'd0);
        repeat (3) tick();
        check_val("rst_mid_empty", {31'd0, bus.mc_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
